// File: rtl/framebuffer_ctrl_pkg.sv
// Shared types, geometry constants and address helper for the double-buffered framebuffer.
// Optional SKY_GRADIENT_EN build macro is consumed by framebuffer_ctrl.
package framebuffer_ctrl_pkg;

    typedef logic [16:0] fb_addr_t;
    typedef logic [2:0]  color_t;

    localparam logic [8:0] FB_W      = 9'd320;
    localparam logic [8:0] FB_H      = 9'd240;
    localparam fb_addr_t   FB_PIXELS = 17'd76800;
    localparam color_t     SKY_COLOR = 3'd6;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
    } screen_xy_t;

    typedef enum logic [2:0] {
        ST_CLEAR   = 3'd0,
        ST_ACK     = 3'd1,
        ST_DRAW    = 3'd2,
        ST_WAIT_VS = 3'd3,
        ST_SWAP    = 3'd4
    } fb_state_t;

    // y*320 + x built from shifts so no multiplier is inferred.
    function automatic fb_addr_t xy_to_addr(input logic [8:0] x, input logic [8:0] y);
        fb_addr_t yw;
        yw = {8'd0, y};
        return (yw << 8) + (yw << 6) + {8'd0, x};
    endfunction

endpackage

// File: rtl/framebuffer_ctrl_fb_bank.sv
// One framebuffer bank: simple dual-port RAM, one write port, one registered read port.
module fb_bank
    import framebuffer_ctrl_pkg::*;
(
    input  logic     clk,
    input  logic     we,
    input  fb_addr_t waddr,
    input  color_t   wdata,
    input  fb_addr_t raddr,
    output color_t   rdata
);

    color_t mem [FB_PIXELS];
    color_t rdata_q;

    // Contents are deliberately not reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/framebuffer_ctrl.sv
// Double-buffered 320x240x3b framebuffer: renderer fills the back bank, VGA scans the front at 2x.
// Build macro SKY_GRADIENT_EN selects a row-banded clear colour instead of flat SKY_COLOR.
module framebuffer_ctrl
    import framebuffer_ctrl_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [16:0] coords_in,
    input  logic [2:0]  color_in,
    input  logic        we_in,
    input  logic        render_done,
    output logic        render_ack,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    input  logic        blank_n,
    input  logic        frame_start,
    output logic [2:0]  pixel_color,
    output logic        front_sel
);

    fb_state_t  state_q, state_d;
    fb_addr_t   clr_addr_q, clr_addr_d;
    logic       front_sel_q, front_sel_d;
    logic       render_ack_q, render_ack_d;
    logic       done_latch_q, done_latch_d;
    logic       blank_d_q, blank_d_d;
    color_t     pixel_color_q, pixel_color_d;

    screen_xy_t coords_s;
    fb_addr_t   draw_addr_s, raddr_s, bank_waddr_s;
    color_t     bank_wdata_s, fill_s, rdata0_s, rdata1_s;
    logic       in_range_s, bank_we_s;
    logic       unused_lsb_s;

    assign coords_s     = coords_in;
    assign draw_addr_s  = xy_to_addr(coords_s.x, {1'b0, coords_s.y});
    assign in_range_s   = (coords_s.x < FB_W) && ({1'b0, coords_s.y} < FB_H);
    assign raddr_s      = xy_to_addr(draw_x[9:1], draw_y[9:1]);
    assign unused_lsb_s = ^{draw_x[0], draw_y[0]};

`ifdef SKY_GRADIENT_EN
    logic [8:0] clr_col_q, clr_col_d;
    logic [7:0] clr_row_q, clr_row_d;
    color_t     band_s;

    // Row band colour derived from a column/row walker that tracks clr_addr.
    always_comb begin
        band_s    = 3'd7 - {1'b0, clr_row_q[7:6]};
        fill_s    = (band_s < 3'd4) ? 3'd4 : band_s;
        clr_col_d = clr_col_q;
        clr_row_d = clr_row_q;
        if (state_q == ST_CLEAR) begin
            if (clr_addr_q == FB_PIXELS - 17'd1) begin
                clr_col_d = 9'd0;
                clr_row_d = 8'd0;
            end else if (clr_col_q == FB_W - 9'd1) begin
                clr_col_d = 9'd0;
                clr_row_d = clr_row_q + 8'd1;
            end else begin
                clr_col_d = clr_col_q + 9'd1;
            end
        end else begin
            clr_col_d = clr_col_q;
        end
    end

    // Row/column walker registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            clr_col_q <= 9'd0;
            clr_row_q <= 8'd0;
        end else begin
            clr_col_q <= clr_col_d;
            clr_row_q <= clr_row_d;
        end
    end
`else
    assign fill_s = SKY_COLOR;
`endif

    // Next-state logic for the bank-management FSM and the read pipeline.
    always_comb begin
        state_d       = state_q;
        clr_addr_d    = clr_addr_q;
        front_sel_d   = front_sel_q;
        render_ack_d  = 1'b0;
        done_latch_d  = done_latch_q;
        bank_we_s     = 1'b0;
        bank_waddr_s  = clr_addr_q;
        bank_wdata_s  = fill_s;
        blank_d_d     = blank_n;
        pixel_color_d = blank_d_q ? (front_sel_q ? rdata1_s : rdata0_s) : 3'd0;
        case (state_q)
            ST_CLEAR: begin
                bank_we_s = 1'b1;
                if (clr_addr_q == FB_PIXELS - 17'd1) begin
                    clr_addr_d   = 17'd0;
                    render_ack_d = 1'b1;
                    state_d      = ST_ACK;
                end else begin
                    clr_addr_d = clr_addr_q + 17'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_DRAW;
            end
            ST_DRAW: begin
                bank_waddr_s = draw_addr_s;
                bank_wdata_s = color_in;
                bank_we_s    = we_in && in_range_s;
                if (render_done) begin
                    done_latch_d = 1'b1;
                    state_d      = ST_WAIT_VS;
                end else begin
                    state_d = ST_DRAW;
                end
            end
            ST_WAIT_VS: begin
                // A frame_start coincident with render_done was seen in DRAW and is not honoured.
                if (frame_start && done_latch_q) begin
                    state_d = ST_SWAP;
                end else begin
                    state_d = ST_WAIT_VS;
                end
            end
            ST_SWAP: begin
                front_sel_d  = ~front_sel_q;
                done_latch_d = 1'b0;
                state_d      = ST_CLEAR;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= ST_CLEAR;
            clr_addr_q    <= 17'd0;
            front_sel_q   <= 1'b0;
            render_ack_q  <= 1'b0;
            done_latch_q  <= 1'b0;
            blank_d_q     <= 1'b0;
            pixel_color_q <= 3'd0;
        end else begin
            state_q       <= state_d;
            clr_addr_q    <= clr_addr_d;
            front_sel_q   <= front_sel_d;
            render_ack_q  <= render_ack_d;
            done_latch_q  <= done_latch_d;
            blank_d_q     <= blank_d_d;
            pixel_color_q <= pixel_color_d;
        end
    end

    // Writes always target the back bank, i.e. the one not selected for display.
    fb_bank u_bank0 (
        .clk   (Clk),
        .we    (bank_we_s && front_sel_q),
        .waddr (bank_waddr_s),
        .wdata (bank_wdata_s),
        .raddr (raddr_s),
        .rdata (rdata0_s)
    );

    fb_bank u_bank1 (
        .clk   (Clk),
        .we    (bank_we_s && !front_sel_q),
        .waddr (bank_waddr_s),
        .wdata (bank_wdata_s),
        .raddr (raddr_s),
        .rdata (rdata1_s)
    );

    assign render_ack  = render_ack_q;
    assign pixel_color = pixel_color_q;
    assign front_sel   = front_sel_q;

endmodule
